ctrl_block_writer: RTL

- Write-side front end for the control-cell block memory.
- Accepts a valid/ready stream of WORD_BITS words, for example compute-array results or host load data.
- Packs each run of BLOCK_WIDTH**2 words into one block-wide word.
- Issues one single-cycle write per block on the memory's write port (write / addr_i / data_i), starting at a commanded base block address.

---
 rtl/ctrl_block_writer.sv | 109 ++++++++++
 1 files changed

// File: rtl/ctrl_block_writer.sv
// rtl/ctrl_block_writer.sv - packs a word stream into square blocks and writes one block per cycle
module ctrl_block_writer #(
  parameter int ADDR_BITS   = 6,
  parameter int BLOCK_WIDTH = 8,
  parameter int WORD_BITS   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [ADDR_BITS-1:0]                    base_addr,
  input  logic [ADDR_BITS:0]                      num_blocks,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [WORD_BITS-1:0]                    in_data,
  output logic                                    mem_write,
  output logic [ADDR_BITS-1:0]                    mem_addr,
  output logic [WORD_BITS*BLOCK_WIDTH*BLOCK_WIDTH-1:0] mem_data,
  output logic                                    busy,
  output logic                                    done
);

  localparam int WORDS = BLOCK_WIDTH * BLOCK_WIDTH;
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DW    = WORD_BITS * WORDS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t               state, state_next;
  logic [KW-1:0]        word_cnt;
  logic [ADDR_BITS:0]   blocks_left;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [DW-1:0]        pack_buf;
  logic [DW-1:0]        pack_next;
  logic                 hs;
  logic                 last_word;

  assign hs        = in_valid & in_ready;
  assign last_word = (word_cnt == KW'(WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_blocks != '0) ? FILL : DONE;
      FILL:    if (hs && last_word) state_next = WRITE;
      WRITE:   state_next = (blocks_left == (ADDR_BITS+1)'(1)) ? DONE : FILL;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Incoming word merged into its row-major slot; word 0 sits at the LSBs.
  always_comb begin
    pack_next = pack_buf;
    pack_next[int'(word_cnt)*WORD_BITS +: WORD_BITS] = in_data;
  end

  // Status strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready    <= 1'b0;
      mem_write   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      pack_buf    <= '0;
      word_cnt    <= '0;
      blocks_left <= '0;
      cur_addr    <= '0;
    end else begin
      in_ready  <= (state_next == FILL);
      mem_write <= (state_next == WRITE);
      busy      <= (state_next == FILL) || (state_next == WRITE);
      done      <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start && num_blocks != '0) begin
            cur_addr    <= base_addr;
            blocks_left <= num_blocks;
            word_cnt    <= '0;
          end
        end
        FILL: begin
          if (hs) begin
            pack_buf <= pack_next;
            if (last_word) begin
              word_cnt <= '0;
              mem_data <= pack_next;
              mem_addr <= cur_addr;
            end else begin
              word_cnt <= word_cnt + KW'(1);
            end
          end
        end
        WRITE: begin
          cur_addr    <= cur_addr + ADDR_BITS'(1);
          blocks_left <= blocks_left - (ADDR_BITS+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
